mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the single-cycle data memory bus.
- Lets the CPU (master 0) and a loader/DMA/debug port (master 1) share one DataMemory instance.
- Latches each winner's command, drives AddressBus/DataBusOut/ControlBus for a programmable number of cycles, returns read data and a one-cycle ack, then switches masters round-robin.
- Sits between the masters and the DataMemory module, which is clocked on ~InputClk.

Parameters:
- DATA_W, 32, width of data buses (matches BIT_WIDTH).
- ADDR_W, 32, width of address buses.
- WAIT_CYCLES, 0, extra memory cycles per access; an access occupies WAIT_CYCLES+1 cycles.

Ports:
- InputClk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data; valid while m0_ack=1, held afterwards.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1.
- AddressBus  out  ADDR_W  to memory.
- DataBusOut  out  DATA_W  to memory write port.
- DataBusIn  in  DATA_W  from memory read port.
- ControlBus  out  3  [0]=access valid, [1]=read enable, [2]=write enable.
- owner  out  1  master currently owning the bus; meaningful while busy=1.
- busy  out  1  high in the ACCESS state.
- xfer_count  out  32  number of completed transactions; wraps at 2^32.

Behaviour:
- Clock and reset: one clock, InputClk. rst is asynchronous and active-low.
- Reset values (rst=0, applied immediately):
  - State IDLE; ControlBus=0, AddressBus=0, DataBusOut=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
  - busy=0, owner=0, xfer_count=0.
  - last_served=1, so master 0 wins the first tie.
- All outputs are registered or decoded from registered state only. No combinational path from m*_req to the bus.
- States: IDLE and ACCESS. Wait counter is max(1, clog2(WAIT_CYCLES+1)) bits wide.
- IDLE:
  - Bus outputs are zero.
  - At a rising edge with any req high, choose a winner:
    - only one requester: that master wins;
    - both requesting: the master != last_served wins.
  - Latch the winner's we/addr/wdata, set owner, cnt=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - AddressBus = latched addr; ControlBus = {we, ~we, 1'b1}.
  - DataBusOut = latched wdata when we=1, otherwise 0.
  - Master inputs are ignored after latching; changing m*_addr mid-access has no effect.
  - If cnt!=0: decrement at each edge.
  - If cnt==0 (completion edge):
    - for a read, capture DataBusIn into owner's rdata; for a write, rdata is unchanged;
    - assert owner's ack for the next cycle only;
    - xfer_count+=1; last_served=owner.
- Re-arbitration at the completion edge:
  - The completing master's req is ignored, since its req is still high.
  - If the other master's req is high, it is latched and ACCESS continues with no idle bubble. The bus stays valid and owner toggles.
  - Otherwise go to IDLE.
- Master protocol:
  - A master keeps req and command stable until it sees ack.
  - req high at the end of its ack cycle is a new request.
- Latency with WAIT_CYCLES=W:
  - req first high in cycle 0;
  - bus driven in cycles 1..W+1;
  - ack in cycle W+2.
- Fairness: with both masters requesting continuously, grants alternate strictly. No master waits more than one transaction.
- Reset mid-ACCESS: the bus drops to 0 asynchronously. No ack is issued for the aborted access, and xfer_count is not incremented. After release, arbitration restarts from IDLE with last_served=1.

Test Plan:
- Reset: pulse rst=0 mid-cycle with m0_req=1 → ControlBus=0, busy=0, xfer_count=0 immediately; the first grant after release goes to M0.
- W=0, M0 writes 0xDEADBEEF to 0x10 in cycle 0:
  - cycle 1: AddressBus=0x10, ControlBus=3'b101, DataBusOut=0xDEADBEEF;
  - cycle 2: m0_ack=1.
  - A following M0 read of 0x10 → ControlBus=3'b011 and m0_rdata=0xDEADBEEF with m0_ack.
- W=0, m0_req and m1_req both rise in cycle 0:
  - M0 owns cycle 1 and M1 owns cycle 2;
  - ControlBus[0]=1 for both cycles with no gap;
  - m0_ack in cycle 2, m1_ack in cycle 3.
- Both masters request reads continuously for 4 transactions → owner sequence 0,1,0,1, xfer_count=4, no master receives two consecutive acks.
- WAIT_CYCLES=2:
  - M1 read of 0x20 requested in cycle 0; m1_addr changed to 0x30 in cycle 2;
  - AddressBus=0x20 for cycles 1–3, m1_ack in cycle 4, data is that of address 0x20.
- WAIT_CYCLES=2: rst=0 asserted in cycle 2 of an M0 write → ControlBus=0 at once, m0_ack never pulses, xfer_count stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Request/acknowledge bundle for one bus master of mem_bus_arbiter.
// The master modport faces a requester; the slave modport faces the arbiter.
interface mem_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle data memory bus.
// It latches the winner's command, holds it on the bus for WAIT_CYCLES+1 cycles, then acks the winner.
module mem_bus_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              InputClk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] DataBusOut,
  input  logic [DATA_W-1:0] DataBusIn,
  output logic [2:0]        ControlBus,
  output logic              owner,
  output logic              busy,
  output logic [31:0]       xfer_count
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, stateNext;
  logic              ownerQ, weQ, lastServed;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [CNT_W-1:0]  cnt;
  logic              done, grant, grantSel;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    grantSel  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          grant     = 1'b1;
          grantSel  = (m0.req && m1.req) ? ~lastServed : m1.req;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          // The finishing master still holds req, so only the other one can take over.
          done      = 1'b1;
          grantSel  = ~ownerQ;
          grant     = ownerQ ? m0.req : m1.req;
          stateNext = grant ? ACCESS : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ACCESS);
    owner      = ownerQ;
    AddressBus = busy ? addrQ : '0;
    DataBusOut = (busy && weQ) ? wdataQ : '0;
    ControlBus = busy ? {weQ, ~weQ, 1'b1} : 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ownerQ     <= 1'b0;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      cnt        <= '0;
      lastServed <= 1'b1;
      xfer_count <= '0;
      m0.ack     <= 1'b0;
      m1.ack     <= 1'b0;
      m0.rdata   <= '0;
      m1.rdata   <= '0;
    end else begin
      state  <= stateNext;
      m0.ack <= done && !ownerQ;
      m1.ack <= done && ownerQ;
      if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        xfer_count <= xfer_count + 32'd1;
        lastServed <= ownerQ;
        if (!weQ) begin
          if (ownerQ) m1.rdata <= DataBusIn;
          else        m0.rdata <= DataBusIn;
        end
      end
      if (grant) begin
        ownerQ <= grantSel;
        weQ    <= grantSel ? m1.we    : m0.we;
        addrQ  <= grantSel ? m1.addr  : m0.addr;
        wdataQ <= grantSel ? m1.wdata : m0.wdata;
        cnt    <= CNT_INIT;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with no wait states, one with two,
// each in front of a small memory model clocked on the falling edge.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: WAIT_CYCLES = 0
  logic        rstA = 1'b0;
  logic [31:0] aAddr, aDout, aXfer;
  logic [31:0] aDin = '0;
  logic [2:0]  aCtl;
  logic        aOwner, aBusy;
  mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) aM0 ();
  mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) aM1 ();

  mem_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(0)) dutA (
    .InputClk(clk), .rst(rstA), .m0(aM0.slave), .m1(aM1.slave),
    .AddressBus(aAddr), .DataBusOut(aDout), .DataBusIn(aDin), .ControlBus(aCtl),
    .owner(aOwner), .busy(aBusy), .xfer_count(aXfer)
  );

  // Instance B: WAIT_CYCLES = 2
  logic        rstB = 1'b0;
  logic [31:0] bAddr, bDout, bXfer;
  logic [31:0] bDin = '0;
  logic [2:0]  bCtl;
  logic        bOwner, bBusy;
  mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bM0 ();
  mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bM1 ();

  mem_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(2)) dutB (
    .InputClk(clk), .rst(rstB), .m0(bM0.slave), .m1(bM1.slave),
    .AddressBus(bAddr), .DataBusOut(bDout), .DataBusIn(bDin), .ControlBus(bCtl),
    .owner(bOwner), .busy(bBusy), .xfer_count(bXfer)
  );

  // Memory models, clocked on the falling edge like DataMemory.
  logic [31:0] memA [logic [31:0]];
  logic [31:0] memB [logic [31:0]];

  always @(negedge clk) begin
    if (aCtl[0] && aCtl[2]) memA[aAddr] = aDout;
    if (aCtl[0] && aCtl[1]) aDin <= memA[aAddr];
    if (bCtl[0] && bCtl[2]) memB[bAddr] = bDout;
    if (bCtl[0] && bCtl[1]) bDin <= memB[bAddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aM0.req = 1'b1; aM0.we = 1'b0; aM0.addr = 32'h40;
    step();
    vectors++; if (aBusy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy: got %b expected 1", aBusy); end
    #2 rstA = 1'b0;
    #1;
    vectors++; if (aCtl !== 3'b000) begin miscompares++; $display("FAIL rst_ctl: got %b expected 000", aCtl); end
    vectors++; if (aBusy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", aBusy); end
    vectors++; if (aXfer !== 32'd0) begin miscompares++; $display("FAIL rst_xfer: got %0d expected 0", aXfer); end
    vectors++; if (aAddr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", aAddr); end
    aM1.req = 1'b1; aM1.we = 1'b0; aM1.addr = 32'h44;
    #1 rstA = 1'b1;
    step();
    vectors++; if (aOwner !== 1'b0 || aBusy !== 1'b1) begin miscompares++; $display("FAIL rst_first_grant: owner %b busy %b expected owner 0 busy 1", aOwner, aBusy); end
    vectors++; if (aAddr !== 32'h40) begin miscompares++; $display("FAIL rst_first_addr: got %h expected 40", aAddr); end
    step();
    vectors++; if (aM0.ack !== 1'b1) begin miscompares++; $display("FAIL rst_m0_ack: got %b expected 1", aM0.ack); end
    vectors++; if (aM0.rdata !== 32'h40404040) begin miscompares++; $display("FAIL rst_m0_rdata: got %h expected 40404040", aM0.rdata); end
    vectors++; if (aOwner !== 1'b1 || aBusy !== 1'b1) begin miscompares++; $display("FAIL rst_second_grant: owner %b busy %b expected owner 1 busy 1", aOwner, aBusy); end
    aM0.req = 1'b0;
    step();
    vectors++; if (aM1.ack !== 1'b1 || aM0.ack !== 1'b0) begin miscompares++; $display("FAIL rst_m1_ack: m1 %b m0 %b expected m1 1 m0 0", aM1.ack, aM0.ack); end
    vectors++; if (aM1.rdata !== 32'h44444444) begin miscompares++; $display("FAIL rst_m1_rdata: got %h expected 44444444", aM1.rdata); end
    aM1.req = 1'b0;
    step();
    vectors++; if (aBusy !== 1'b0 || aXfer !== 32'd2) begin miscompares++; $display("FAIL rst_idle: busy %b xfer %0d expected busy 0 xfer 2", aBusy, aXfer); end
  endtask

  task automatic test_write_read();
    aM0.req = 1'b1; aM0.we = 1'b1; aM0.addr = 32'h10; aM0.wdata = 32'hDEADBEEF;
    step();
    vectors++; if (aAddr !== 32'h10) begin miscompares++; $display("FAIL wr_addr: got %h expected 10", aAddr); end
    vectors++; if (aCtl !== 3'b101) begin miscompares++; $display("FAIL wr_ctl: got %b expected 101", aCtl); end
    vectors++; if (aDout !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_dout: got %h expected deadbeef", aDout); end
    vectors++; if (aM0.ack !== 1'b0) begin miscompares++; $display("FAIL wr_early_ack: got %b expected 0", aM0.ack); end
    step();
    vectors++; if (aM0.ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got %b expected 1", aM0.ack); end
    vectors++; if (aCtl !== 3'b000) begin miscompares++; $display("FAIL wr_ctl_idle: got %b expected 000", aCtl); end
    aM0.we = 1'b0;
    step();
    vectors++; if (aCtl !== 3'b011 || aAddr !== 32'h10) begin miscompares++; $display("FAIL rd_bus: ctl %b addr %h expected 011 10", aCtl, aAddr); end
    vectors++; if (aDout !== 32'h0) begin miscompares++; $display("FAIL rd_dout: got %h expected 0", aDout); end
    vectors++; if (aM0.ack !== 1'b0) begin miscompares++; $display("FAIL rd_early_ack: got %b expected 0", aM0.ack); end
    step();
    vectors++; if (aM0.ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b expected 1", aM0.ack); end
    vectors++; if (aM0.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rdata: got %h expected deadbeef", aM0.rdata); end
    aM0.req = 1'b0;
    step();
    vectors++; if (aM0.rdata !== 32'hDEADBEEF || aXfer !== 32'd4) begin miscompares++; $display("FAIL rd_hold: rdata %h xfer %0d expected deadbeef 4", aM0.rdata, aXfer); end
  endtask

  task automatic test_back_to_back();
    rstA = 1'b0;
    #1 rstA = 1'b1;
    aM0.req = 1'b1; aM0.we = 1'b1; aM0.addr = 32'h50; aM0.wdata = 32'h11111111;
    aM1.req = 1'b1; aM1.we = 1'b1; aM1.addr = 32'h54; aM1.wdata = 32'h22222222;
    step();
    vectors++; if (aOwner !== 1'b0 || aCtl !== 3'b101) begin miscompares++; $display("FAIL b2b_c1: owner %b ctl %b expected 0 101", aOwner, aCtl); end
    vectors++; if (aAddr !== 32'h50 || aDout !== 32'h11111111) begin miscompares++; $display("FAIL b2b_c1_bus: addr %h dout %h expected 50 11111111", aAddr, aDout); end
    step();
    vectors++; if (aOwner !== 1'b1 || aCtl[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_c2: owner %b valid %b expected 1 1", aOwner, aCtl[0]); end
    vectors++; if (aAddr !== 32'h54 || aDout !== 32'h22222222) begin miscompares++; $display("FAIL b2b_c2_bus: addr %h dout %h expected 54 22222222", aAddr, aDout); end
    vectors++; if (aM0.ack !== 1'b1 || aM1.ack !== 1'b0) begin miscompares++; $display("FAIL b2b_c2_ack: m0 %b m1 %b expected 1 0", aM0.ack, aM1.ack); end
    aM0.req = 1'b0;
    step();
    vectors++; if (aM1.ack !== 1'b1 || aM0.ack !== 1'b0) begin miscompares++; $display("FAIL b2b_c3_ack: m1 %b m0 %b expected 1 0", aM1.ack, aM0.ack); end
    vectors++; if (aBusy !== 1'b0 || aXfer !== 32'd2) begin miscompares++; $display("FAIL b2b_c3_idle: busy %b xfer %0d expected 0 2", aBusy, aXfer); end
    aM1.req = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int ack0 = 0;
    int ack1 = 0;
    int lastAck = -1;
    int ownerSeq[$];
    int expSeq[4] = '{0, 1, 0, 1};
    logic [31:0] xferStart = aXfer;
    aM0.req = 1'b1; aM0.we = 1'b0; aM0.addr = 32'h40;
    aM1.req = 1'b1; aM1.we = 1'b0; aM1.addr = 32'h44;
    for (int c = 0; c < 20 && (ack0 + ack1) < 4; c++) begin
      step();
      if (aBusy) ownerSeq.push_back(int'(aOwner));
      if (aM0.ack) begin
        vectors++; if (lastAck == 0) begin miscompares++; $display("FAIL fair_consec_m0: got two m0 acks expected alternation"); end
        lastAck = 0; ack0++;
        if (ack0 == 2) aM0.req = 1'b0;
      end
      if (aM1.ack) begin
        vectors++; if (lastAck == 1) begin miscompares++; $display("FAIL fair_consec_m1: got two m1 acks expected alternation"); end
        lastAck = 1; ack1++;
        if (ack1 == 2) aM1.req = 1'b0;
      end
    end
    aM0.req = 1'b0; aM1.req = 1'b0;
    vectors++; if (ack0 + ack1 != 4) begin miscompares++; $display("FAIL fair_timeout: got %0d acks expected 4", ack0 + ack1); end
    vectors++; if (ownerSeq.size() != 4) begin miscompares++; $display("FAIL fair_len: got %0d busy cycles expected 4", ownerSeq.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= ownerSeq.size() || ownerSeq[i] != expSeq[i]) begin
        miscompares++; $display("FAIL fair_owner%0d: got %0d expected %0d", i, (i < ownerSeq.size()) ? ownerSeq[i] : -1, expSeq[i]);
      end
    end
    vectors++; if (aXfer !== xferStart + 32'd4) begin miscompares++; $display("FAIL fair_xfer: got %0d expected %0d", aXfer, xferStart + 32'd4); end
    vectors++; if (aM1.rdata !== 32'h44444444) begin miscompares++; $display("FAIL fair_rdata: got %h expected 44444444", aM1.rdata); end
    step();
  endtask

  task automatic test_wait_cycles();
    bM1.req = 1'b1; bM1.we = 1'b0; bM1.addr = 32'h20;
    step();
    vectors++; if (bAddr !== 32'h20 || bCtl !== 3'b011 || bOwner !== 1'b1) begin miscompares++; $display("FAIL wait_c1: addr %h ctl %b owner %b expected 20 011 1", bAddr, bCtl, bOwner); end
    step();
    vectors++; if (bAddr !== 32'h20) begin miscompares++; $display("FAIL wait_c2_addr: got %h expected 20", bAddr); end
    bM1.addr = 32'h30;
    step();
    vectors++; if (bAddr !== 32'h20 || bBusy !== 1'b1) begin miscompares++; $display("FAIL wait_c3: addr %h busy %b expected 20 1", bAddr, bBusy); end
    vectors++; if (bM1.ack !== 1'b0) begin miscompares++; $display("FAIL wait_c3_ack: got %b expected 0", bM1.ack); end
    step();
    vectors++; if (bM1.ack !== 1'b1) begin miscompares++; $display("FAIL wait_c4_ack: got %b expected 1", bM1.ack); end
    vectors++; if (bM1.rdata !== 32'hA5A50020) begin miscompares++; $display("FAIL wait_rdata: got %h expected a5a50020", bM1.rdata); end
    vectors++; if (bBusy !== 1'b0 || bXfer !== 32'd1) begin miscompares++; $display("FAIL wait_idle: busy %b xfer %0d expected 0 1", bBusy, bXfer); end
    bM1.req = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    bM0.req = 1'b1; bM0.we = 1'b1; bM0.addr = 32'h60; bM0.wdata = 32'h77777777;
    step();
    step();
    vectors++; if (bBusy !== 1'b1 || bCtl !== 3'b101) begin miscompares++; $display("FAIL abort_pre: busy %b ctl %b expected 1 101", bBusy, bCtl); end
    #2 rstB = 1'b0;
    #1;
    vectors++; if (bCtl !== 3'b000 || bBusy !== 1'b0) begin miscompares++; $display("FAIL abort_bus: ctl %b busy %b expected 000 0", bCtl, bBusy); end
    vectors++; if (bXfer !== 32'd0) begin miscompares++; $display("FAIL abort_xfer: got %0d expected 0", bXfer); end
    bM0.req = 1'b0;
    #1 rstB = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++; if (bM0.ack !== 1'b0 || bBusy !== 1'b0) begin miscompares++; $display("FAIL abort_post%0d: ack %b busy %b expected 0 0", c, bM0.ack, bBusy); end
    end
    vectors++; if (bXfer !== 32'd0) begin miscompares++; $display("FAIL abort_xfer_end: got %0d expected 0", bXfer); end
  endtask

  initial begin
    memA[32'h40] = 32'h40404040;
    memA[32'h44] = 32'h44444444;
    memB[32'h20] = 32'hA5A50020;
    memB[32'h30] = 32'h5A5A0030;
    aM0.req = 1'b0; aM0.we = 1'b0; aM0.addr = '0; aM0.wdata = '0;
    aM1.req = 1'b0; aM1.we = 1'b0; aM1.addr = '0; aM1.wdata = '0;
    bM0.req = 1'b0; bM0.we = 1'b0; bM0.addr = '0; bM0.wdata = '0;
    bM1.req = 1'b0; bM1.we = 1'b0; bM1.addr = '0; bM1.wdata = '0;
    step();
    step();
    rstA = 1'b1;
    rstB = 1'b1;
    step();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_fairness();
    test_wait_cycles();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
